// File: rtl/alk_mdseq.sv
// Multiply/divide sequencer for the ALK datapath: SETUP, N iterate steps, optional
// divide fixup, then a one-cycle done pulse. All outputs are registered.
module alk_mdseq #(
  parameter logic [9:0] ALPCTL_NOP   = 10'h000,
  parameter logic [9:0] ALPCTL_SETUP = 10'h080,
  parameter logic [9:0] ALPCTL_MUL   = 10'h0C0,
  parameter logic [9:0] ALPCTL_DIV   = 10'h0D0,
  parameter logic [9:0] ALPCTL_REM   = 10'h0E0,
  parameter logic [9:0] ALPCTL_FIX   = 10'h0F0,
  parameter logic [5:0] ROT_STEP     = 6'b001000,
  parameter logic [5:0] ROT_FIX      = 6'b000001
) (
  input  logic       qdclk_l,
  input  logic       reset_h,
  input  logic       start_h,
  input  logic [1:0] op_h,
  input  logic [1:0] size_h,
  input  logic       hold_h,
  input  logic       abort_h,
  input  logic       c31_h,
  output logic [9:0] alpctl_h,
  output logic [5:0] rot_h,
  output logic [1:0] dsize_h,
  output logic       busy_h,
  output logic       done_h,
  output logic       err_h,
  output logic [5:0] step_h
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ITER, S_FIX, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] dsize_q, dsize_d;
  logic [5:0] step_q, step_d;
  logic [9:0] alp_q, alp_d;
  logic [5:0] rot_q, rot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dsize_d = dsize_q;
    step_d  = step_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_h) begin
          if (op_h == 2'b11) begin
            err_d = 1'b1;
          end else begin
            op_d    = op_h;
            dsize_d = size_h;
            case (size_h)
              2'b00:   step_d = 6'd8;
              2'b01:   step_d = 6'd16;
              default: step_d = 6'd32;
            endcase
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP, S_ITER, S_FIX: begin
        // Abort wins over hold so a stalled datapath can still be cancelled.
        if (abort_h) begin
          state_d = S_IDLE;
          step_d  = 6'd0;
          err_d   = 1'b1;
        end else if (!hold_h) begin
          if (state_q == S_SETUP) begin
            state_d = S_ITER;
          end else if (state_q == S_FIX) begin
            state_d = S_DONE;
          end else begin
            if (step_q != 6'd0) step_d = step_q - 6'd1;
            if (step_q <= 6'd1) begin
              // Divide needs a restore step when the final carry is clear.
              if (op_q == 2'b00 || c31_h) state_d = S_DONE;
              else                        state_d = S_FIX;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered, so a held state re-drives its command.
    alp_d  = ALPCTL_NOP;
    rot_d  = 6'd0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_SETUP: begin
        alp_d  = ALPCTL_SETUP;
        rot_d  = ROT_STEP;
        busy_d = 1'b1;
      end
      S_ITER: begin
        case (op_d)
          2'b01:   alp_d = ALPCTL_DIV;
          2'b10:   alp_d = ALPCTL_REM;
          default: alp_d = ALPCTL_MUL;
        endcase
        rot_d  = ROT_STEP;
        busy_d = 1'b1;
      end
      S_FIX: begin
        alp_d  = ALPCTL_FIX;
        rot_d  = ROT_FIX;
        busy_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge qdclk_l) begin
    if (reset_h) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      dsize_q <= 2'b00;
      step_q  <= 6'd0;
      alp_q   <= ALPCTL_NOP;
      rot_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dsize_q <= dsize_d;
      step_q  <= step_d;
      alp_q   <= alp_d;
      rot_q   <= rot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign alpctl_h = alp_q;
  assign rot_h    = rot_q;
  assign dsize_h  = dsize_q;
  assign busy_h   = busy_q;
  assign done_h   = done_q;
  assign err_h    = err_q;
  assign step_h   = step_q;

endmodule

// File: doc/alk_mdseq.md
Name: alk_mdseq

Overview:
- Sequencer for the ALK multiply/divide datapath. On a start request it drives the ALK control fields: the opcode field (`alpctl_h`), the rotate/shift/carry-in field (`rot_h`) and the data size field (`dsize_h`).
- Issues one setup step, then N iterate steps, where N comes from the data size. Division may add an optional restore/fixup step. Completion is reported with a one-cycle done pulse.
- Sits between the microsequencer-side request logic and the ALK control inputs. Replaces hand-coded microloops for MUL/DIV/REM.

Parameters:
- `ALPCTL_NOP`, default 10'h000: opcode driven when idle.
- `ALPCTL_SETUP`, default 10'h080: setup opcode (loads Q, clears loop flag).
- `ALPCTL_MUL`, default 10'h0C0: multiply iterate opcode.
- `ALPCTL_DIV`, default 10'h0D0: divide iterate opcode.
- `ALPCTL_REM`, default 10'h0E0: remainder iterate opcode.
- `ALPCTL_FIX`, default 10'h0F0: divide/remainder restore (fixup) opcode.
- `ROT_STEP`, default 6'b001000: rotate field for setup and iterate steps (ALUSHF=010 = shift, ALUCI=00).
- `ROT_FIX`, default 6'b000001: rotate field for the fixup step (no shift, ALUCI=01).

Ports:
- `qdclk_l` in 1: clock. All state updates on its rising edge.
- `reset_h` in 1: synchronous reset, active high.
- `start_h` in 1: request. Sampled only in IDLE.
- `op_h` in 2: operation; 00=MUL, 01=DIV, 10=REM, 11=reserved.
- `size_h` in 2: operand size; 00=byte, 01=word, 10/11=long.
- `hold_h` in 1: datapath stall. Freezes the sequencer and re-drives the current step.
- `abort_h` in 1: cancel the operation in progress.
- `c31_h` in 1: ALU carry from the ALK datapath. Sampled on the last iterate step.
- `alpctl_h` out 10: opcode to the ALK.
- `rot_h` out 6: rotate/shift/carry-in field to the ALK.
- `dsize_h` out 2: data size to the ALK.
- `busy_h` out 1: high from the SETUP state through the FIX state.
- `done_h` out 1: one-cycle completion pulse.
- `err_h` out 1: one-cycle pulse on a reserved op or on abort.
- `step_h` out 6: iterate steps remaining (debug).

Behaviour:
- Reset values: state=IDLE, `alpctl_h=ALPCTL_NOP`, `rot_h=0`, `dsize_h=0`, `busy_h=0`, `done_h=0`, `err_h=0`, `step_h=0`.
- Outputs are registered. The command for a state appears in the cycle that state is entered.
- States: IDLE, SETUP, ITER, FIX, DONE.
- IDLE:
  - `start_h` with `op_h` != 11: latch `op_h` and `size_h` internally; set `dsize_h=size_h`; load `step_h` with N (8/16/32); go to SETUP.
  - `start_h` with `op_h`=11: pulse `err_h`; stay in IDLE.
- SETUP: `alpctl_h=ALPCTL_SETUP`, `rot_h=ROT_STEP`. Next cycle goes to ITER.
- ITER:
  - `alpctl_h` = MUL, DIV or REM opcode per the latched op; `rot_h=ROT_STEP`.
  - `step_h` decrements by 1 each non-held cycle.
  - When the decrement makes `step_h` 0:
    - MUL goes to DONE.
    - DIV/REM: if `c31_h`=0 in the final iterate cycle, go to FIX; else go to DONE.
- FIX: `alpctl_h=ALPCTL_FIX`, `rot_h=ROT_FIX`, for one cycle. Then go to DONE.
- DONE:
  - `done_h=1`, `busy_h=0`, `alpctl_h=ALPCTL_NOP`, `rot_h=0`.
  - Next cycle returns to IDLE with `done_h=0`.
  - `start_h` is not accepted in DONE. Back-to-back operations therefore have a minimum spacing of one IDLE cycle.
- Latency (no hold, start accepted at cycle 0):
  - SETUP at cycle 1.
  - ITER at cycles 2..N+1.
  - FIX, if taken, at cycle N+2.
  - `done_h` at cycle N+2, or N+3 when FIX is taken.
- `hold_h`:
  - Applies in SETUP, ITER and FIX only.
  - State, `step_h` and all outputs are frozen; the current command is re-driven.
  - `c31_h` is ignored while held. The final-step sample uses the non-held cycle.
  - `hold_h` in IDLE or DONE has no effect.
- `abort_h`:
  - Active in SETUP, ITER or FIX, and takes priority over `hold_h`.
  - Next cycle: IDLE, `alpctl_h=ALPCTL_NOP`, `rot_h=0`, `busy_h=0`, `err_h` pulsed, no `done_h`.
- `abort_h` in IDLE or DONE is ignored.
- `reset_h` mid-operation forces reset values in the next cycle. No `done_h` or `err_h` is generated.
- Inputs `op_h`, `size_h` and `start_h` are ignored while busy. A latched `size_h`=11 is treated as long (N=32).
- `step_h` never underflows. It holds 0 outside ITER once an operation completes.

Test Plan:
- MUL long: `start_h`=1, `op_h`=00, `size_h`=10, no hold → SETUP at cycle 1; 32 cycles of `alpctl_h`=0C0 (cycles 2..33); `done_h`=1 at cycle 34 only; `busy_h` high for cycles 1..33.
- DIV byte with `c31_h`=0 on the final step → 8 cycles of 0D0, then one cycle of 0F0 with `rot_h`=000001, then `done_h` at cycle 11. Same run with `c31_h`=1 → no FIX, `done_h` at cycle 10.
- REM word with `hold_h` high for 3 cycles at step 5 → `alpctl_h`=0E0 and `step_h`=11 stable for 3 cycles; `done_h` at cycle 21 (18+3); exactly 16 non-held iterate cycles.
- `abort_h` at ITER step 20 of MUL long → next cycle `alpctl_h`=000, `busy_h`=0, `err_h` high 1 cycle, no `done_h`; a new `start_h` on the following cycle is accepted.
- `op_h`=11 start → `err_h` pulse, `busy_h` stays 0. `start_h` held high continuously through MUL byte → second op starts only after one IDLE cycle following `done_h`.
- `reset_h` asserted during FIX → next cycle all outputs at reset values, no `done_h`.
